// File: rtl/count_uart_tx.sv
// count_uart_tx: serialises one byte per valid/ready handshake as a UART 8N1
// frame (start bit, DATA_W data bits LSB first, one stop bit) on tx.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high, in_ready high, waiting for in_valid
// S_START | start bit (tx=0) for CLKS_PER_BIT cycles
// S_DATA  | shift register bit 0 on tx, one bit per CLKS_PER_BIT cycles
// S_STOP  | stop bit (tx=1); frame_done pulses in the first IDLE cycle after
module count_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [DIV_W-1:0]  div, div_nxt;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic              frame_done_nxt;
  logic              bit_end;

  assign bit_end = (div == DIV_LAST);

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      div        <= '0;
      bit_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      div        <= div_nxt;
      bit_idx    <= bit_idx_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Next-state logic: divider restarts at every bit boundary so bits never drift.
  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    div_nxt        = div;
    bit_idx_nxt    = bit_idx;
    frame_done_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          shreg_nxt   = in_data;
          div_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          div_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = S_DATA;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          div_nxt   = '0;
          shreg_nxt = shreg >> 1;
          if (bit_idx == IDX_LAST) begin
            bit_idx_nxt = '0;
            state_nxt   = S_STOP;
          end else begin
            bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          div_nxt        = '0;
          state_nxt      = S_IDLE;
          frame_done_nxt = 1'b1;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Line level decoded from state and shift register only, never from inputs.
  always_comb begin
    tx = 1'b1;
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = shreg[0];
      default: tx = 1'b1;
    endcase
  end

  assign in_ready = (state == S_IDLE);
  assign busy     = ~in_ready;

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx: three instances (4, 2 and 16 clocks per bit),
// a table of frames with hand-derived line patterns, reset/isolation
// sequences, and a randomized run against an arithmetic frame model.
module tb_count_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [7:0] d_a = 8'h00, d_b = 8'h00, d_c = 8'h00;
  logic       v_a = 1'b0, v_b = 1'b0, v_c = 1'b0;
  logic tx_a, rdy_a, busy_a, fd_a;
  logic tx_b, rdy_b, busy_b, fd_b;
  logic tx_c, rdy_c, busy_c, fd_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(d_a), .in_valid(v_a),
    .in_ready(rdy_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a));

  count_uart_tx #(.CLKS_PER_BIT(2), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(d_b), .in_valid(v_b),
    .in_ready(rdy_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b));

  count_uart_tx #(.CLKS_PER_BIT(16), .DATA_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(d_c), .in_valid(v_c),
    .in_ready(rdy_c), .tx(tx_c), .busy(busy_c), .frame_done(fd_c));

  // {tx, in_ready, busy, frame_done}
  function automatic logic [3:0] outs(input int i);
    case (i)
      0:       return {tx_a, rdy_a, busy_a, fd_a};
      1:       return {tx_b, rdy_b, busy_b, fd_b};
      default: return {tx_c, rdy_c, busy_c, fd_c};
    endcase
  endfunction

  task automatic drive(input int i, input logic [7:0] d, input logic v);
    case (i)
      0:       begin d_a = d; v_a = v; end
      1:       begin d_b = d; v_b = v; end
      default: begin d_c = d; v_c = v; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {tx,rdy,busy,done}=%b want %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: expected outputs k cycles after an accept edge for byte b.
  function automatic logic [3:0] model(input int k, input int cpb, input logic [7:0] b);
    int p;
    logic bitv;
    if (k >= 1 && k <= 10 * cpb) begin
      p = (k - 1) / cpb;
      if (p == 0)      bitv = 1'b0;
      else if (p <= 8) bitv = b[p-1];
      else             bitv = 1'b1;
      return {bitv, 3'b010};
    end else if (k == 10 * cpb + 1) begin
      return 4'b1101;
    end
    return 4'b1100;
  endfunction

  // Accept a byte on the next edge and check every cycle of its frame against
  // a precomputed 10-bit line pattern (bit i = i-th transmitted bit).
  task automatic run_frame(input int i, input int cpb, input logic [7:0] d,
                           input logic [9:0] fr, input bit hold, input bit scramble,
                           input string nm);
    logic [3:0] o;
    drive(i, d, 1'b1);
    tick();
    if (!hold) drive(i, d, 1'b0);
    for (int k = 1; k <= 10 * cpb; k++) begin
      o = outs(i);
      chk({nm, "_bit"}, o, {fr[(k-1)/cpb], 3'b010});
      if (scramble) drive(i, 8'($urandom), (k == 10 * cpb) ? 1'b0 : 1'($urandom));
      tick();
    end
    o = outs(i);
    chk({nm, "_done"}, o, 4'b1101);
  endtask

  typedef struct {
    int         inst;
    int         cpb;
    logic [7:0] data;
    logic [9:0] frame;
    bit         hold;
    bit         scramble;
    string      name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0,  4, 8'hA5, 10'h34A, 1'b0, 1'b0, "single_a5"};
    vecs[1] = '{0,  4, 8'h00, 10'h200, 1'b1, 1'b0, "b2b_00"};
    vecs[2] = '{0,  4, 8'hFF, 10'h3FE, 1'b0, 1'b0, "b2b_ff"};
    vecs[3] = '{0,  4, 8'h3C, 10'h278, 1'b0, 1'b1, "isolate_3c"};
    vecs[4] = '{1,  2, 8'h55, 10'h2AA, 1'b1, 1'b0, "cpb2_55a"};
    vecs[5] = '{1,  2, 8'h55, 10'h2AA, 1'b0, 1'b0, "cpb2_55b"};
    vecs[6] = '{2, 16, 8'h5A, 10'h2B4, 1'b1, 1'b0, "cpb16_a"};
    vecs[7] = '{2, 16, 8'h5A, 10'h2B4, 1'b0, 1'b0, "cpb16_b"};

    // Reset values, before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk("reset_vals", outs(i), 4'b1100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Idle stability.
    for (int n = 0; n < 100; n++) begin
      chk("idle", outs(0), 4'b1100);
      tick();
    end

    // Table of frames.
    for (int t = 0; t < 8; t++) begin
      run_frame(vecs[t].inst, vecs[t].cpb, vecs[t].data, vecs[t].frame,
                vecs[t].hold, vecs[t].scramble, vecs[t].name);
      if (!vecs[t].hold) begin
        for (int n = 0; n < 3; n++) begin
          tick();
          chk({vecs[t].name, "_after"}, outs(vecs[t].inst), 4'b1100);
        end
      end
    end

    // Reset mid-frame during data bit 3 of 0x81.
    drive(0, 8'h81, 1'b1);
    tick();
    drive(0, 8'h81, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      chk("rst_pre_bit", outs(0), {model(k, 4, 8'h81)});
      tick();
    end
    chk("rst_pre_bit3", outs(0), 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", outs(0), 4'b1100);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("rst_release", outs(0), 4'b1100);
    for (int n = 0; n < 45; n++) begin
      tick();
      chk("rst_no_done", outs(0), 4'b1100);
    end
    run_frame(0, 4, 8'h42, 10'h284, 1'b0, 1'b0, "post_rst_42");
    repeat (3) tick();

    // Randomized traffic against the frame model.
    begin
      int e;
      int now;
      int k;
      logic [7:0] fb;
      logic [7:0] d;
      logic v;
      logic rdy;
      e = -100000;
      now = 0;
      fb = 8'h00;
      for (int n = 0; n < 1500; n++) begin
        k = now - e + 1;
        chk("rand", outs(0), model(k, 4, fb));
        v = ($urandom_range(0, 3) == 0);
        d = 8'($urandom);
        drive(0, d, v);
        rdy = !(k >= 1 && k <= 40);
        tick();
        now++;
        if (v && rdy) begin
          e = now;
          fb = d;
        end
      end
      drive(0, 8'h00, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
